// File: rtl/bus_arbiter_rr_pkg.sv
// Shared types, sizes and the round-robin pick helper for the bus arbiter.
package bus_arbiter_rr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam int NUM_REQ            = 4;
    localparam int DEFAULT_MAX_TENURE = 8;
    localparam int CNT_W              = 8;

    // First set request bit scanning upward from ptr, wrapping 3->0.
    // Returns ptr when nothing is requested; callers only use the result
    // when at least one bit is set.
    function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                           input logic [1:0]         ptr);
        logic [1:0] idx;
        logic [1:0] win;
        logic       found;
        win   = ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface bus_arbiter_rr_if;
    import bus_arbiter_rr_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [1:0]         gnt_id;
    logic               gnt_valid;
    logic               busy;

    modport master (
        output req,
        input  gnt,
        input  gnt_id,
        input  gnt_valid,
        input  busy
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_id,
        output gnt_valid,
        output busy
    );

endinterface

// File: rtl/bus_arbiter_rr_decoder.sv
// 2-to-4 one-hot decoder with enable; all outputs low when en is low.
module decoder2_4 (
    input  logic [1:0] data,
    input  logic       en,
    output logic [3:0] y
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dec
            assign y[gi] = en && (data == 2'(gi));
        end
    endgenerate

endmodule

// File: rtl/bus_arbiter_rr.sv
// Four-way round-robin bus arbiter with bounded tenure and a one-cycle
// turnaround (RELEASE) between owners.
module bus_arbiter_rr
    import bus_arbiter_rr_pkg::*;
#(
    parameter int MAX_TENURE = DEFAULT_MAX_TENURE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    bus_arbiter_rr_if.slave        bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_TENURE - 1);

    state_t             state_reg, state_next;
    logic [1:0]         owner_reg, owner_next;
    logic [1:0]         ptr_reg, ptr_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [NUM_REQ-1:0] gnt_reg;
    logic               gnt_valid_reg;
    logic               busy_reg;
    logic [NUM_REQ-1:0] dec_out;
    logic [NUM_REQ-1:0] others;
    logic               at_limit;

    // Requests other than the current owner's, and the tenure boundary.
    assign others   = bus.req & ~(NUM_REQ'(1) << owner_reg);
    assign at_limit = (cnt_reg == CNT_LAST);

    // Next-state logic: arbitration in IDLE/RELEASE, tenure policing in GRANT.
    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE, ST_RELEASE: begin
                if (|bus.req) begin
                    state_next = ST_GRANT;
                    owner_next = rr_pick(bus.req, ptr_reg);
                    cnt_next   = '0;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!bus.req[owner_reg] || (at_limit && (|others))) begin
                    state_next = ST_RELEASE;
                    ptr_next   = owner_reg + 2'd1;
                    cnt_next   = '0;
                end else if (at_limit) begin
                    // Nobody else waiting: the lone owner keeps the bus.
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // The decoder sees the values the owner/state registers are about to
    // take, so the registered grant lines up with them in the same cycle
    // and the grant latency stays at one edge.
    decoder2_4 u_dec (
        .data (owner_next),
        .en   (state_next == ST_GRANT),
        .y    (dec_out)
    );

    // State, pointer, counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            owner_reg     <= 2'd0;
            ptr_reg       <= 2'd0;
            cnt_reg       <= '0;
            gnt_reg       <= '0;
            gnt_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            ptr_reg       <= ptr_next;
            cnt_reg       <= cnt_next;
            gnt_reg       <= dec_out;
            gnt_valid_reg <= (state_next == ST_GRANT);
            busy_reg      <= (state_next != ST_IDLE);
        end
    end

    assign bus.gnt       = gnt_reg;
    assign bus.gnt_id    = owner_reg;
    assign bus.gnt_valid = gnt_valid_reg;
    assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: a per-cycle behavioural model checked on every
// falling edge, plus directed scenarios with literal expectations.
module tb_bus_arbiter_rr;

    localparam int MAXT = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    bus_arbiter_rr_if bus_if ();

    bus_arbiter_rr #(.MAX_TENURE(MAXT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model: who owns the bus, how long they've held it, whether this is a
    // turnaround cycle, and where the next scan starts.
    int m_owner = -1;
    int m_held  = 0;
    int m_start = 0;
    bit m_turn  = 1'b0;
    bit m_live  = 1'b0;

    always @(posedge clk) begin
        logic [3:0] r;
        bit ends;
        r      = bus_if.req;
        m_live = 1'b1;
        if (!rst_n) begin
            m_owner = -1;
            m_held  = 0;
            m_start = 0;
            m_turn  = 1'b0;
        end else if (m_owner >= 0) begin
            ends = !r[m_owner] ||
                   ((m_held == MAXT - 1) && ((r & ~(4'b0001 << m_owner)) != 4'b0000));
            if (ends) begin
                m_start = (m_owner + 1) % 4;
                m_owner = -1;
                m_turn  = 1'b1;
            end else begin
                m_held = (m_held + 1) % MAXT;
            end
        end else begin
            m_turn = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (m_owner < 0 && r[(m_start + k) % 4]) m_owner = (m_start + k) % 4;
            end
            m_held = 0;
        end
    end

    // Per-cycle comparison against the model plus the grant-shape invariants.
    always @(negedge clk) begin
        if (m_live) begin
            check("model_gnt", int'(bus_if.gnt), (m_owner >= 0) ? (1 << m_owner) : 0);
            check("model_valid", int'(bus_if.gnt_valid), (m_owner >= 0) ? 1 : 0);
            check("model_busy", int'(bus_if.busy), (m_owner >= 0 || m_turn) ? 1 : 0);
            if (m_owner >= 0) check("model_gnt_id", int'(bus_if.gnt_id), m_owner);
            check("gnt_onehot", ($countones(bus_if.gnt) <= 1) ? 1 : 0, 1);
            check("valid_is_or", int'(bus_if.gnt_valid), int'(|bus_if.gnt));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        bus_if.req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [3:0] vec_tbl [12] = '{4'b1010, 4'b1010, 4'b1000, 4'b0001, 4'b0101, 4'b0101,
                                 4'b0000, 4'b1111, 4'b0111, 4'b0011, 4'b0000, 4'b0110};

    initial begin
        int held;
        int exp_gnt;

        bus_if.req = 4'b0000;
        rst_n      = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_gnt", int'(bus_if.gnt), 0);
        check("reset_gnt_id", int'(bus_if.gnt_id), 0);
        check("reset_valid", int'(bus_if.gnt_valid), 0);
        check("reset_busy", int'(bus_if.busy), 0);
        $display("txn reset: gnt=%b busy=%b", bus_if.gnt, bus_if.busy);
        rst_n = 1'b1;

        // Single request, release, back to idle.
        bus_if.req = 4'b0100;
        @(negedge clk);
        check("single_gnt", int'(bus_if.gnt), 4'b0100);
        check("single_gnt_id", int'(bus_if.gnt_id), 2);
        bus_if.req = 4'b0000;
        @(negedge clk);
        check("single_release_gnt", int'(bus_if.gnt), 0);
        check("single_release_busy", int'(bus_if.busy), 1);
        @(negedge clk);
        check("single_idle_busy", int'(bus_if.busy), 0);
        $display("txn single: req=0100 granted id 2, released");

        // Rotation with all four requesting: 8 owned cycles + 1 turnaround each.
        do_reset();
        bus_if.req = 4'b1111;
        for (int k = 0; k < 44; k++) begin
            @(negedge clk);
            exp_gnt = ((k % 9) < 8) ? (1 << ((k / 9) % 4)) : 0;
            check("rotation_gnt", int'(bus_if.gnt), exp_gnt);
        end
        $display("txn rotation: req=1111 for 44 cycles");

        // Lone owner keeps the bus through counter wrap.
        do_reset();
        bus_if.req = 4'b0001;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("lone_gnt", int'(bus_if.gnt), 4'b0001);
        end
        $display("txn lone: req=0001 for 20 cycles");

        // Pointer wrap: owner 3 preempted by requester 0.
        do_reset();
        bus_if.req = 4'b1000;
        @(negedge clk);
        check("wrap_first_gnt", int'(bus_if.gnt), 4'b1000);
        bus_if.req = 4'b1001;
        held = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus_if.gnt != 4'b1000) break;
            held++;
        end
        check("wrap_tenure", held, MAXT);
        check("wrap_release_gnt", int'(bus_if.gnt), 0);
        @(negedge clk);
        check("wrap_next_gnt", int'(bus_if.gnt), 4'b0001);
        $display("txn wrap: owner 3 held %0d cycles, next grant %b", held, bus_if.gnt);

        // Reset in the middle of a grant to requester 2.
        do_reset();
        bus_if.req = 4'b0100;
        repeat (3) @(negedge clk);
        check("midrst_pre_gnt", int'(bus_if.gnt), 4'b0100);
        rst_n      = 1'b0;
        bus_if.req = 4'b0110;
        @(negedge clk);
        check("midrst_gnt", int'(bus_if.gnt), 0);
        check("midrst_busy", int'(bus_if.busy), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_next_gnt", int'(bus_if.gnt), 4'b0010);
        check("midrst_next_id", int'(bus_if.gnt_id), 1);
        $display("txn midreset: next grant %b", bus_if.gnt);

        // Drop and re-raise: owner 1 loses its claim; scan restarts at 2.
        do_reset();
        bus_if.req = 4'b0010;
        @(negedge clk);
        check("drop_gnt", int'(bus_if.gnt), 4'b0010);
        bus_if.req = 4'b0100;
        @(negedge clk);
        check("drop_release_gnt", int'(bus_if.gnt), 0);
        bus_if.req = 4'b0110;
        @(negedge clk);
        check("drop_next_gnt", int'(bus_if.gnt), 4'b0100);
        $display("txn drop: re-raised requester 1 passed over, grant %b", bus_if.gnt);

        // Mixed request patterns, checked by the model each cycle.
        foreach (vec_tbl[i]) begin
            bus_if.req = vec_tbl[i];
            repeat (3) @(negedge clk);
            $display("txn table: req=%b gnt=%b busy=%b", vec_tbl[i], bus_if.gnt, bus_if.busy);
        end
        bus_if.req = 4'b0000;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
